// File: rtl/array_loader.sv
// Stream-to-matrix loader: collects 8-element frames into a fill buffer
// and hands complete frames to a held A/B register pair.
module array_loader #(
  parameter int NBITS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NBITS-1:0] DIN,
  input  logic             DIN_VALID,
  input  logic             DIN_LAST,
  output logic             DIN_READY,
  output logic [NBITS-1:0] A [2][2],
  output logic [NBITS-1:0] B [2][2],
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [7:0]       FRAME_CNT,
  output logic             ERR
);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state;
  state_t           state_nx;
  logic [2:0]       idx;
  logic [NBITS-1:0] fbuf [8];
  logic [NBITS-1:0] hold [8];

  logic accept;
  logic at_end;
  logic complete;
  logic bad;
  logic load_now;
  logic load_full;
  logic drain;

  assign accept    = DIN_VALID && DIN_READY;
  assign at_end    = (idx == 3'd7);
  assign complete  = accept && at_end && DIN_LAST;
  assign bad       = accept && (at_end != DIN_LAST);
  assign load_now  = complete && (!OUT_VALID || OUT_READY);
  assign load_full = (state == FULL) && OUT_READY;
  assign drain     = (state == FILL) && !complete
                     && OUT_VALID && OUT_READY;

  always_ff @(posedge CLK) begin
    if (RST) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: if (complete && OUT_VALID && !OUT_READY)
              state_nx = FULL;
      FULL: if (OUT_READY)
              state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_comb begin
    DIN_READY = (state == FILL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx       <= '0;
      OUT_VALID <= 1'b0;
      ERR       <= 1'b0;
      FRAME_CNT <= '0;
      for (int i = 0; i < 8; i++) begin
        fbuf[i] <= '0;
        hold[i] <= '0;
      end
    end else begin
      ERR <= bad;
      if (accept) begin
        fbuf[idx] <= DIN;
        idx       <= (complete || bad) ? 3'd0 : idx + 3'd1;
      end
      // the last element bypasses the buffer on a direct load
      if (load_now) begin
        for (int i = 0; i < 7; i++)
          hold[i] <= fbuf[i];
        hold[7] <= DIN;
      end else if (load_full) begin
        for (int i = 0; i < 8; i++)
          hold[i] <= fbuf[i];
      end
      if (load_now || load_full) begin
        OUT_VALID <= 1'b1;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end else if (drain) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_row
    for (genvar j = 0; j < 2; j++) begin : g_col
      assign A[i][j] = hold[2*i + j];
      assign B[i][j] = hold[4 + 2*i + j];
    end
  end

endmodule

// File: tb/tb_array_loader.sv
// Bench for array_loader: vector table, directed corner cases and
// randomized traffic against a frame-level reference model.
module tb_array_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_last = 1'b0;
  logic        din_ready;
  logic [15:0] a [2][2];
  logic [15:0] b [2][2];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  frame_cnt;
  logic        err;

  array_loader #(.NBITS(16)) dut (
    .CLK(clk), .RST(rst),
    .DIN(din), .DIN_VALID(din_valid), .DIN_LAST(din_last),
    .DIN_READY(din_ready),
    .A(a), .B(b),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .FRAME_CNT(frame_cnt), .ERR(err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: frame-level view of the loader
  logic [15:0] m_q [$];
  logic [15:0] m_hold [8];
  logic [15:0] m_pend [8];
  bit          m_has_pend;
  bit          m_ov;
  bit          m_err;
  logic [7:0]  m_cnt;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 8; i++) begin
      m_hold[i] = '0;
      m_pend[i] = '0;
    end
    m_has_pend = 0;
    m_ov  = 0;
    m_err = 0;
    m_cnt = '0;
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [15:0] d,
                            input bit l, input bit o);
    bit done;
    done  = 0;
    m_err = 0;
    if (r) begin
      model_reset();
    end else if (m_has_pend) begin
      if (o) begin
        m_hold = m_pend;
        m_has_pend = 0;
        m_cnt++;
      end
    end else begin
      if (v) begin
        m_q.push_back(d);
        if (l && m_q.size() == 8) begin
          done = 1;
          if (!m_ov || o) begin
            for (int i = 0; i < 8; i++) m_hold[i] = m_q[i];
            m_ov = 1;
            m_cnt++;
          end else begin
            for (int i = 0; i < 8; i++) m_pend[i] = m_q[i];
            m_has_pend = 1;
          end
          m_q.delete();
        end else if (l || m_q.size() == 8) begin
          m_err = 1;
          m_q.delete();
        end
      end
      if (!done && m_ov && o) m_ov = 0;
    end
  endtask

  function automatic logic [127:0] dut_ab();
    return {a[0][0], a[0][1], a[1][0], a[1][1],
            b[0][0], b[0][1], b[1][0], b[1][1]};
  endfunction

  function automatic logic [127:0] mdl_ab();
    logic [127:0] x;
    for (int i = 0; i < 8; i++) x[127-16*i -: 16] = m_hold[i];
    return x;
  endfunction

  task automatic step(input bit r, input bit v, input logic [15:0] d,
                      input bit l, input bit o);
    rst = r; din_valid = v; din = d; din_last = l; out_ready = o;
    @(posedge clk);
    model_edge(r, v, d, l, o);
    #1;
    chk("din_ready", 128'(din_ready), 128'(!m_has_pend));
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("frame_cnt", 128'(frame_cnt), 128'(m_cnt));
    chk("err", 128'(err), 128'(m_err));
    chk("ab", dut_ab(), mdl_ab());
  endtask

  task automatic send_frame(input int base, input bit o);
    for (int k = 0; k < 8; k++)
      step(0, 1, 16'(base + k), k == 7, o);
  endtask

  typedef struct {
    bit          r, v, l, o;
    logic [15:0] d;
    bit          e_rdy, e_ov, e_err;
    logic [15:0] e_a00, e_b11;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tv [12];
  int   err_seen;

  initial begin
    model_reset();
    tv[0] = '{r:1, v:0, l:0, o:0, d:0, e_rdy:1, e_ov:0, e_err:0,
              e_a00:0, e_b11:0, e_cnt:0};
    for (int k = 1; k <= 8; k++)
      tv[k] = '{r:0, v:1, l:(k == 8), o:1, d:16'(k), e_rdy:1,
                e_ov:(k == 8), e_err:0, e_a00:(k == 8) ? 16'd1 : 16'd0,
                e_b11:(k == 8) ? 16'd8 : 16'd0, e_cnt:(k == 8) ? 8'd1 : 8'd0};
    tv[9]  = '{r:0, v:0, l:0, o:0, d:16'hdead, e_rdy:1, e_ov:1, e_err:0,
               e_a00:1, e_b11:8, e_cnt:1};
    tv[10] = '{r:0, v:0, l:1, o:1, d:16'hbeef, e_rdy:1, e_ov:0, e_err:0,
               e_a00:1, e_b11:8, e_cnt:1};
    tv[11] = '{r:0, v:0, l:0, o:0, d:16'h0, e_rdy:1, e_ov:0, e_err:0,
               e_a00:1, e_b11:8, e_cnt:1};

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(tv[i].r, tv[i].v, tv[i].d, tv[i].l, tv[i].o);
      chk("tv_rdy", 128'(din_ready), 128'(tv[i].e_rdy));
      chk("tv_ov", 128'(out_valid), 128'(tv[i].e_ov));
      chk("tv_a00", 128'(a[0][0]), 128'(tv[i].e_a00));
      chk("tv_b11", 128'(b[1][1]), 128'(tv[i].e_b11));
      chk("tv_cnt", 128'(frame_cnt), 128'(tv[i].e_cnt));
      chk("tv_err", 128'(err), 128'(tv[i].e_err));
    end

    // back-pressure: second frame parks in the fill buffer
    step(1, 0, 0, 0, 0);
    send_frame(1, 0);
    send_frame(9, 0);
    chk("bp_rdy", 128'(din_ready), 128'(0));
    chk("bp_a00", 128'(a[0][0]), 128'(1));
    step(0, 1, 16'd99, 1, 0);
    chk("bp_hold_a00", 128'(a[0][0]), 128'(1));
    step(0, 1, 16'd77, 0, 1);
    chk("bp_rel_a00", 128'(a[0][0]), 128'(9));
    chk("bp_rel_a11", 128'(a[1][1]), 128'(12));
    chk("bp_rel_cnt", 128'(frame_cnt), 128'(2));
    chk("bp_rel_rdy", 128'(din_ready), 128'(1));
    step(0, 0, 0, 0, 1);

    // early LAST on the 5th element
    for (int k = 0; k < 5; k++) step(0, 1, 16'(50 + k), k == 4, 1);
    chk("fe_err", 128'(err), 128'(1));
    chk("fe_ov", 128'(out_valid), 128'(0));
    step(0, 0, 0, 0, 1);
    chk("fe_err_clr", 128'(err), 128'(0));
    send_frame(21, 1);
    chk("fe_a00", 128'(a[0][0]), 128'(21));
    chk("fe_cnt", 128'(frame_cnt), 128'(3));

    // missing LAST on the 8th element
    for (int k = 0; k < 8; k++) step(0, 1, 16'(60 + k), 0, 1);
    chk("nl_err", 128'(err), 128'(1));
    chk("nl_a00", 128'(a[0][0]), 128'(21));

    // gapped valid; idle cycles carry junk that must be ignored
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 16'(41 + k), k == 7, 1);
      if (k == 7) begin
        chk("gap_ov", 128'(out_valid), 128'(1));
        chk("gap_a00", 128'(a[0][0]), 128'(41));
        chk("gap_b11", 128'(b[1][1]), 128'(48));
      end
      step(0, 0, 16'hffff, 1, 1);
    end

    // reset mid-frame discards the partial frame
    for (int k = 0; k < 4; k++) step(0, 1, 16'(70 + k), 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_ov", 128'(out_valid), 128'(0));
    chk("rst_a00", 128'(a[0][0]), 128'(0));
    send_frame(31, 1);
    chk("rst_a", 128'({a[0][0], a[0][1], a[1][0], a[1][1]}),
        {64'd0, 16'd31, 16'd32, 16'd33, 16'd34});
    chk("rst_cnt", 128'(frame_cnt), 128'(1));

    // counter wrap over 256 frames
    step(1, 0, 0, 0, 0);
    err_seen = 0;
    for (int f = 0; f < 256; f++)
      for (int k = 0; k < 8; k++) begin
        step(0, 1, 16'(f * 8 + k), k == 7, 1);
        if (err) err_seen++;
      end
    chk("wrap_cnt", 128'(frame_cnt), 128'(0));
    chk("wrap_err", 128'(err_seen), 128'(0));
    chk("wrap_ov", 128'(out_valid), 128'(1));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v, l, o;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 8) l = (m_q.size() == 7);
      else                          l = $urandom_range(0, 1) == 1;
      step(r, v, 16'($urandom), l, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/array_loader.md
ARRAY_LOADER -- requirements
Module: array_loader

Interface
REQ-001 Parameter: NBITS, 16, element width of every array element and of DIN.
REQ-002 Port: CLK  in  1  single clock, all state updates on rising edge.
REQ-003 Port: RST  in  1  reset, synchronous and active-high.
REQ-004 Port: DIN  in  NBITS  stream element.
REQ-005 Port: DIN_VALID  in  1  DIN holds a valid element.
REQ-006 Port: DIN_LAST  in  1  marks the final element of a frame; qualified by DIN_VALID.
REQ-007 Port: DIN_READY  out  1  loader accepts an element this cycle.
REQ-008 Port: A  out  NBITS x [2][2]  unpacked array, held frame, first matrix.
REQ-009 Port: B  out  NBITS x [2][2]  unpacked array, held frame, second matrix.
REQ-010 Port: OUT_VALID  out  1  A/B hold a complete frame.
REQ-011 Port: OUT_READY  in  1  consumer takes the held frame.
REQ-012 Port: FRAME_CNT  out  8  count of frames delivered to the hold register, wraps 255->0.
REQ-013 Port: ERR  out  1  one-cycle pulse on framing error.

Function
REQ-014 Frame SHALL be 8 elements in order A[0][0], A[0][1], A[1][0], A[1][1], B[0][0], B[0][1], B[1][0], B[1][1]; DIN_LAST SHALL be high on element 8 only.
REQ-015 Transfer SHALL occur on any cycle with DIN_VALID=1 and DIN_READY=1; accepted element written to fill buffer at index IDX (3-bit), IDX increments.
REQ-016 Datapath SHALL be two registers: fill buffer (8 x NBITS) and hold register (A, B); A/B SHALL be driven only from the hold register.
REQ-017 FSM states SHALL be FILL and FULL; DIN_READY SHALL be 1 exactly in FILL, decoded from the state register only.
REQ-018 FILL, element accepted with IDX=7 and DIN_LAST=1: frame complete.
REQ-019 On frame complete, if OUT_VALID=0 or OUT_READY=1 that cycle, fill buffer (incl. the element being accepted) SHALL load the hold register at the same edge; OUT_VALID=1 next cycle; state stays FILL; IDX=0.
REQ-020 On frame complete with OUT_VALID=1 and OUT_READY=0: state SHALL go FULL; IDX=0.
REQ-021 FULL: when OUT_READY=1 (OUT_VALID is 1), hold SHALL load the fill buffer, OUT_VALID stays 1, state goes FILL.
REQ-022 In FILL, OUT_VALID=1 and OUT_READY=1 with no frame completing: OUT_VALID SHALL go 0 next cycle; A/B retain their last value.
REQ-023 Latency: last element accepted at edge N -> OUT_VALID=1 with new A/B after edge N (visible cycle N+1) when the hold register is free; sustained throughput 8 cycles per frame with OUT_READY held 1.
REQ-024 Framing error: accepted element with DIN_LAST=1 and IDX<7, or IDX=7 and DIN_LAST=0: ERR=1 for the next cycle, frame discarded, IDX=0, hold register, OUT_VALID, FRAME_CNT unchanged.
REQ-025 FRAME_CNT SHALL increment by 1 on each hold-register load (REQ-019, REQ-021); modulo 256.
REQ-026 DIN, DIN_LAST SHALL be ignored when DIN_VALID=0 or DIN_READY=0.
REQ-027 A/B SHALL remain stable while OUT_VALID=1 and OUT_READY=0.

Reset
REQ-028 RST=1 at a rising edge SHALL set state FILL, IDX=0, OUT_VALID=0, ERR=0, FRAME_CNT=0, A and B all elements 0, fill buffer 0; takes priority over every other event.
REQ-029 Reset mid-frame or in FULL SHALL discard partial and pending frames; first post-reset accepted element is A[0][0].

Verification
REQ-030 Reset, then stream 1..8 back-to-back with LAST on 8, OUT_READY=1 -> next cycle A={{1,2},{3,4}}, B={{5,6},{7,8}}, OUT_VALID=1, FRAME_CNT=1.
REQ-031 OUT_READY=0, send frames 1..8 then 9..16 -> after 2nd frame DIN_READY=0, A still {{1,2},{3,4}}; raise OUT_READY one cycle -> A={{9,10},{11,12}}, FRAME_CNT=2, DIN_READY=1.
REQ-032 DIN_LAST on 5th element -> ERR pulse 1 cycle, OUT_VALID unchanged; following good frame 21..28 delivered with A[0][0]=21.
REQ-033 DIN_VALID toggled 1/0 every cycle across a frame -> same A/B as gap-free case, delivery 1 cycle after 8th acceptance.
REQ-034 RST asserted after 4 elements, then full frame 31..38 -> A={{31,32},{33,34}}, FRAME_CNT=1.
REQ-035 256 consecutive good frames with OUT_READY=1 -> FRAME_CNT wraps to 0, no ERR.
